// File: rtl/sha256_pkg.sv
// ============================================================================
// Module   : sha256_pkg
// Purpose  : Shared SHA-256 definitions: word width, message-schedule state
//            encoding and the small-sigma functions s0/s1 used by the schedule.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int WIN_LEN = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x,
                                            input int unsigned      n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // s0(x) = ror7 ^ ror18 ^ shr3
  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  // s1(x) = ror17 ^ ror19 ^ shr10
  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_sched_word.sv
// ============================================================================
// Module   : sha256_sched_word
// Purpose  : Combinational new-word generator for the SHA-256 message
//            schedule: new = s1(win14) + win9 + s0(win1) + win0 (mod 2^32).
// Ports    : win_0, win_1, win_9, win_14 - window taps (oldest = win_0)
//            new_word                    - next schedule word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] win_0,
  input  logic [WORD_W-1:0] win_1,
  input  logic [WORD_W-1:0] win_9,
  input  logic [WORD_W-1:0] win_14,
  output logic [WORD_W-1:0] new_word
);

  // Sum is taken at WORD_W bits so carries out of the top bit drop naturally.
  always_comb begin
    new_word = sig1(win_14) + win_9 + sig0(win_1) + win_0;
  end

endmodule

`default_nettype wire

// File: rtl/sha256_msg_sched.sv
// ============================================================================
// Module   : sha256_msg_sched
// Purpose  : SHA-256 message schedule generator. Accepts one 512-bit block,
//            then streams W[0..ROUNDS-1] over a valid/ready interface using a
//            16-word sliding window.
// Ports    : clk, reset (sync, active high)
//            load_valid/load_ready/block - block input handshake
//            w_valid/w_ready/w_data       - schedule word output handshake
//            w_index, w_last              - word index, last-word flag
//            busy                         - high while streaming
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [BLOCK_W-1:0] block,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WORD_W-1:0]  w_data,
  output logic [5:0]         w_index,
  output logic               w_last,
  output logic               busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  generate
    if (ROUNDS < 16 || ROUNDS > 64) begin : g_rounds_check
      $error("sha256_msg_sched: ROUNDS must be within 16..64");
    end
  endgenerate

  sched_state_t      r_state;
  sched_state_t      w_next_state;
  logic [WORD_W-1:0] r_win [WIN_LEN];
  logic [5:0]        r_index;
  logic [WORD_W-1:0] w_new_word;
  logic              w_load_fire;
  logic              w_word_fire;
  logic              w_at_last;

  assign w_at_last = (r_index == LAST_IDX);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    load_ready   = 1'b0;
    w_valid      = 1'b0;
    busy         = 1'b0;
    w_load_fire  = 1'b0;
    w_word_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_load_fire  = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        // load_valid is deliberately not looked at here: no queuing.
        w_valid = 1'b1;
        busy    = 1'b1;
        if (w_ready) begin
          w_word_fire = 1'b1;
          if (w_at_last) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Window and index. The final handshake leaves both untouched so the index
  // saturates at ROUNDS-1 instead of wrapping.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        r_win[i] <= '0;
      end
      r_index <= '0;
    end else if (w_load_fire) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        r_win[i] <= block[WORD_W*i +: WORD_W];
      end
      r_index <= '0;
    end else if (w_word_fire && !w_at_last) begin
      for (int i = 0; i < WIN_LEN - 1; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[WIN_LEN-1] <= w_new_word;
      r_index          <= r_index + 6'd1;
    end
  end

  sha256_sched_word u_sched_word (
    .win_0    (r_win[0]),
    .win_1    (r_win[1]),
    .win_9    (r_win[9]),
    .win_14   (r_win[14]),
    .new_word (w_new_word)
  );

  assign w_data  = r_win[0];
  assign w_index = r_index;
  assign w_last  = w_valid && w_at_last;

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
// ============================================================================
// Module   : tb_sha256_msg_sched
// Purpose  : Self-checking bench for sha256_msg_sched (ROUNDS=64 and 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_msg_sched;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [511:0] block;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_index;
  logic         w_last;
  logic         busy;

  logic         load_valid16;
  logic         load_ready16;
  logic [511:0] block16;
  logic         w_valid16;
  logic         w_ready16;
  logic [31:0]  w_data16;
  logic [5:0]   w_index16;
  logic         w_last16;
  logic         busy16;

  int checks;
  int errors;

  logic [31:0] exp_w [64];

  localparam logic [511:0] ABC_BLK  = {32'h00000018, 448'h0, 32'h61626380};
  localparam logic [511:0] ONES_BLK = {512{1'b1}};
  localparam logic [511:0] ALT_BLK  = {16{32'hDEADBEEF}};

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .block      (block),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_index    (w_index),
    .w_last     (w_last),
    .busy       (busy)
  );

  sha256_msg_sched #(.ROUNDS(16)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid16),
    .load_ready (load_ready16),
    .block      (block16),
    .w_valid    (w_valid16),
    .w_ready    (w_ready16),
    .w_data     (w_data16),
    .w_index    (w_index16),
    .w_last     (w_last16),
    .busy       (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: textbook recurrence over a flat 64-entry array.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  // Offers blk at a negedge, returns at the negedge after the handshake
  // and checks that W0 appears with one cycle of latency.
  task automatic load_block(input logic [511:0] blk);
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_before_load: got %b want 1", load_ready);
    end
    load_valid = 1'b1;
    block      = blk;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (w_valid !== 1'b1 || w_index !== 6'd0 || w_data !== blk[31:0]) begin
      errors++;
      $display("FAIL load_latency: got valid=%b idx=%0d data=%h want valid=1 idx=0 data=%h",
               w_valid, w_index, w_data, blk[31:0]);
    end
  endtask

  // mode 0: w_ready=1; mode 1: random w_ready; mode 2: w_ready=1 with an
  // alternate block offered while running.
  task automatic stream64(input int mode);
    int          idx;
    int          cyc;
    logic        rdy;
    logic        stalled;
    logic [31:0] pd;
    logic [5:0]  pi;
    logic        pl;
    idx = 0; cyc = 0; stalled = 1'b0; pd = '0; pi = '0; pl = 1'b0;
    while (idx < 64 && cyc < 2000) begin
      cyc++;
      checks++;
      if (w_valid !== 1'b1 || load_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_flags idx=%0d: got valid=%b load_ready=%b busy=%b want 1/0/1",
                 idx, w_valid, load_ready, busy);
        break;
      end
      if (stalled) begin
        checks++;
        if (w_data !== pd || w_index !== pi || w_last !== pl) begin
          errors++;
          $display("FAIL stall_stable idx=%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   idx, w_data, w_index, w_last, pd, pi, pl);
        end
      end
      checks++;
      if (w_data !== exp_w[idx]) begin
        errors++;
        $display("FAIL word idx=%0d: got %h want %h", idx, w_data, exp_w[idx]);
      end
      checks++;
      if (w_index !== 6'(idx)) begin
        errors++;
        $display("FAIL index: got %0d want %0d", w_index, idx);
      end
      checks++;
      if (w_last !== (idx == 63)) begin
        errors++;
        $display("FAIL last idx=%0d: got %b want %b", idx, w_last, (idx == 63));
      end
      if (mode != 1 && idx == 16) begin
        checks++;
        if (w_data !== 32'h61626380 && exp_w[0] == 32'h61626380) begin
          errors++;
          $display("FAIL abc_w16: got %h want 61626380", w_data);
        end
      end
      if (mode != 1 && idx == 17) begin
        checks++;
        if (w_data !== 32'h000F0000 && exp_w[0] == 32'h61626380) begin
          errors++;
          $display("FAIL abc_w17: got %h want 000f0000", w_data);
        end
      end
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && (idx == 5 || idx == 40)) begin
        load_valid = 1'b1;
        block      = ALT_BLK;
      end else begin
        load_valid = 1'b0;
      end
      w_ready = rdy;
      stalled = !rdy;
      pd = w_data; pi = w_index; pl = w_last;
      if (rdy) idx++;
      @(negedge clk);
    end
    w_ready    = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL stream_timeout: got %0d words want 64", idx);
    end
    checks++;
    if (load_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0 || w_last !== 1'b0) begin
      errors++;
      $display("FAIL end_state: got load_ready=%b valid=%b busy=%b last=%b want 1/0/0/0",
               load_ready, w_valid, busy, w_last);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || w_valid !== 1'b0 || w_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got load_ready=%b valid=%b last=%b busy=%b want 1/0/0/0",
               load_ready, w_valid, w_last, busy);
    end
    checks++;
    if (w_index !== 6'd0 || w_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got idx=%0d data=%h want 0/0", w_index, w_data);
    end
    checks++;
    if (load_ready16 !== 1'b1 || w_valid16 !== 1'b0 || w_data16 !== 32'h0) begin
      errors++;
      $display("FAIL reset_r16: got load_ready=%b valid=%b data=%h want 1/0/0",
               load_ready16, w_valid16, w_data16);
    end
    reset = 1'b0;
  endtask

  task automatic test_abc;
    build_model(ABC_BLK);
    load_block(ABC_BLK);
    stream64(0);
  endtask

  task automatic test_abc_random_ready;
    build_model(ABC_BLK);
    load_block(ABC_BLK);
    stream64(1);
  endtask

  task automatic test_load_during_run;
    build_model(ABC_BLK);
    load_block(ABC_BLK);
    stream64(2);
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    build_model(ABC_BLK);
    load_block(ABC_BLK);
    w_ready = 1'b1;
    cyc = 0;
    while (w_index != 6'd20 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (w_index !== 6'd20 || w_data !== exp_w[20]) begin
      errors++;
      $display("FAIL reach_idx20: got idx=%0d data=%h want 20/%h", w_index, w_data, exp_w[20]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    w_ready = 1'b0;
    checks++;
    if (w_valid !== 1'b0 || load_ready !== 1'b1 || w_index !== 6'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b load_ready=%b idx=%0d busy=%b want 0/1/0/0",
               w_valid, load_ready, w_index, busy);
    end
    build_model(ABC_BLK);
    load_block(ABC_BLK);
    stream64(0);
  endtask

  task automatic test_all_ones;
    build_model(ONES_BLK);
    load_block(ONES_BLK);
    stream64(0);
  endtask

  task automatic test_rounds16;
    logic [511:0] blk;
    int           idx;
    int           cyc;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = 32'h01010101 * (i + 1) + 32'h0A000000;
    @(negedge clk);
    load_valid16 = 1'b1;
    block16      = blk;
    @(negedge clk);
    load_valid16 = 1'b0;
    w_ready16    = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 100) begin
      cyc++;
      checks++;
      if (w_valid16 !== 1'b1 || w_data16 !== blk[32*idx +: 32] || w_index16 !== 6'(idx)) begin
        errors++;
        $display("FAIL r16_word idx=%0d: got valid=%b data=%h idx=%0d want 1/%h/%0d",
                 idx, w_valid16, w_data16, w_index16, blk[32*idx +: 32], idx);
      end
      checks++;
      if (w_last16 !== (idx == 15)) begin
        errors++;
        $display("FAIL r16_last idx=%0d: got %b want %b", idx, w_last16, (idx == 15));
      end
      idx++;
      @(negedge clk);
    end
    w_ready16 = 1'b0;
    checks++;
    if (w_valid16 !== 1'b0 || load_ready16 !== 1'b1 || w_index16 !== 6'd15) begin
      errors++;
      $display("FAIL r16_end: got valid=%b load_ready=%b idx=%0d want 0/1/15",
               w_valid16, load_ready16, w_index16);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    load_valid   = 1'b0;
    block        = '0;
    w_ready      = 1'b0;
    load_valid16 = 1'b0;
    block16      = '0;
    w_ready16    = 1'b0;
    test_reset();
    test_abc();
    test_abc_random_ready();
    test_load_during_run();
    test_reset_mid_run();
    test_all_ones();
    test_rounds16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
